// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, frame width, divisor and vote helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam int DATA_BITS = 8;

  // Rounded clk cycles per oversample tick. The transmitter uses ovs=1.
  function automatic int calc_div(input int clk_hz, input int baud, input int ovs);
    return (clk_hz + (baud * ovs) / 2) / (baud * ovs);
  endfunction

  // 2-of-3 majority vote.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clk, restartable.
// Latency: first tick DIV clk after restart; tick is decoded from the counter.
// Backpressure: none; free-running.
// Ports: clk, rst (sync, active-high), restart (zero the phase), tick (out).
module uart_baud_tick #(
  parameter int DIV = 78
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_8n1.sv
// UART 8N1 receiver with 3-sample majority vote and a valid/ack holding register.
// Latency: rx_valid rises about 2 + (9*OVS + OVS/2 + 2)*DIV clk after the start edge.
// Backpressure: none on the line; an unacked byte is overwritten and flags overrun.
// Ports: clk, rst (sync, active-high), rx (async line), rxbyte/rx_valid/rx_ack
//        (byte handshake), overrun (sticky), frame_err (pulse), busy.
module uart_rx_8n1
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD        = 9600,
  parameter int OVS         = 16,
  parameter int DIV         = calc_div(CLK_FREQ_HZ, BAUD, OVS)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rxbyte,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       overrun,
  output logic       frame_err,
  output logic       busy
);

  localparam int SW = $clog2(OVS);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [SW-1:0] S_V0   = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] S_V1   = SW'(OVS / 2);
  localparam logic [SW-1:0] S_V2   = SW'(OVS / 2 + 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVS - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  logic          rx_m, rx_s;
  state_t        state;
  logic [SW-1:0] scnt;
  logic [BW-1:0] bidx;
  logic [7:0]    shreg;
  logic          smp0, smp1;
  logic          tick, restart, vote, at_vote, at_end;

  // Synchroniser resets high so a low line at reset release is not a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Realign the tick phase to the start edge.
  assign restart = (state == IDLE) && !rx_s;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  // The third sample is the live rx_s at the vote point.
  assign vote    = maj3(smp0, smp1, rx_s);
  assign at_vote = tick && (scnt == S_V2);
  assign at_end  = tick && (scnt == S_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      scnt      <= '0;
      bidx      <= '0;
      shreg     <= '0;
      smp0      <= 1'b0;
      smp1      <= 1'b0;
      rxbyte    <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_err <= 1'b0;

      // A capture further down overrides this clear on the same edge.
      if (rx_ack && rx_valid) rx_valid <= 1'b0;

      if (tick && scnt == S_V0) smp0 <= rx_s;
      if (tick && scnt == S_V1) smp1 <= rx_s;

      if (tick && state != IDLE) scnt <= (scnt == S_LAST) ? '0 : scnt + 1'b1;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            scnt  <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (at_vote && vote) begin
            state <= IDLE;      // glitch, not a start bit
            busy  <= 1'b0;
          end else if (at_end) begin
            state <= DATA;
            bidx  <= '0;
          end
        end
        DATA: begin
          if (at_vote) shreg <= {vote, shreg[7:1]};
          if (at_end) begin
            if (bidx == B_LAST) state <= STOP;
            else bidx <= bidx + 1'b1;
          end
        end
        STOP: begin
          // Leave at the vote point so a back-to-back start edge is not missed.
          if (at_vote) begin
            if (vote) begin
              rxbyte   <= shreg;
              rx_valid <= 1'b1;
              if (rx_valid) overrun <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_8n1.sv
module tb_uart_rx_8n1;

  localparam int OVS  = 16;
  localparam int DIV  = 4;
  localparam int BITC = OVS * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       ack_man = 1'b0;
  logic       ack_auto = 1'b0;
  logic       auto_ack = 1'b0;
  logic       rx_ack;
  logic [7:0] rxbyte;
  logic       rx_valid, overrun, frame_err, busy;

  assign rx_ack = ack_man | ack_auto;

  uart_rx_8n1 #(.OVS(OVS), .DIV(DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rxbyte    (rxbyte),
    .rx_valid  (rx_valid),
    .rx_ack    (rx_ack),
    .overrun   (overrun),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Monitor: bytes at rx_valid rising edges, frame_err cycles, over-long pulses.
  logic [7:0] cap_q[$];
  int   fe_cnt = 0;
  int   fe_long = 0;
  logic prev_v = 1'b0;
  logic prev_fe = 1'b0;

  always @(negedge clk) begin
    if (rx_valid && !prev_v) cap_q.push_back(rxbyte);
    if (frame_err) fe_cnt++;
    if (frame_err && prev_fe) fe_long++;
    prev_v  = rx_valid;
    prev_fe = frame_err;
  end

  // Consumer that acks each byte one cycle after it appears.
  always @(negedge clk) begin
    ack_auto = auto_ack && rx_valid && !ack_auto;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    hold(BITC);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      hold(BITC);
    end
    rx = stop;
    hold(BITC);
    rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       aack;
    int         gap;
    logic       ack_after;
    int         exp_new;
    logic [7:0] exp_byte;
    logic       exp_valid;
    int         exp_fe;
    logic       exp_ovr;
  } vec_t;

  vec_t vt[7];

  int caps0, fe0, fl0;

  initial begin
    //            data   stop  aack  gap  ackA  new byte   vld   fe ovr
    vt[0] = '{8'h44, 1'b1, 1'b0, 20,  1'b1, 1, 8'h44, 1'b1, 0, 1'b0};
    vt[1] = '{8'h55, 1'b1, 1'b1, 0,   1'b0, 1, 8'h55, 1'b0, 0, 1'b0};
    vt[2] = '{8'hA3, 1'b1, 1'b1, 20,  1'b0, 1, 8'hA3, 1'b0, 0, 1'b0};
    vt[3] = '{8'h0F, 1'b0, 1'b0, 100, 1'b0, 0, 8'hA3, 1'b0, 1, 1'b0};
    vt[4] = '{8'h81, 1'b1, 1'b0, 20,  1'b1, 1, 8'h81, 1'b1, 0, 1'b0};
    vt[5] = '{8'h11, 1'b1, 1'b0, 20,  1'b0, 1, 8'h11, 1'b1, 0, 1'b0};
    vt[6] = '{8'h22, 1'b1, 1'b0, 20,  1'b1, 0, 8'h22, 1'b1, 0, 1'b1};

    // Reset state
    rst = 1'b1;
    hold(5);
    settle();
    chk("reset rxbyte", rxbyte, 8'h00);
    chk("reset rx_valid", rx_valid, 1'b0);
    chk("reset overrun", overrun, 1'b0);
    chk("reset frame_err", frame_err, 1'b0);
    chk("reset busy", busy, 1'b0);
    rst = 1'b0;
    hold(50);
    settle();
    chk("idle busy", busy, 1'b0);

    // Table-driven frames
    for (int k = 0; k < 7; k++) begin
      caps0 = cap_q.size();
      fe0   = fe_cnt;
      fl0   = fe_long;
      auto_ack = vt[k].aack;
      send(vt[k].data, vt[k].stop);
      hold(vt[k].gap);
      settle();
      chk($sformatf("v%0d new bytes", k), cap_q.size() - caps0, vt[k].exp_new);
      if (vt[k].exp_new > 0 && cap_q.size() > 0)
        chk($sformatf("v%0d captured byte", k), cap_q[$], vt[k].exp_byte);
      chk($sformatf("v%0d rxbyte", k), rxbyte, vt[k].exp_byte);
      chk($sformatf("v%0d rx_valid", k), rx_valid, vt[k].exp_valid);
      chk($sformatf("v%0d frame_err count", k), fe_cnt - fe0, vt[k].exp_fe);
      chk($sformatf("v%0d frame_err width", k), fe_long - fl0, 0);
      chk($sformatf("v%0d overrun", k), overrun, vt[k].exp_ovr);
      if (vt[k].ack_after) begin
        ack_man = 1'b1;
        hold(1);
        ack_man = 1'b0;
        settle();
        chk($sformatf("v%0d rx_valid after ack", k), rx_valid, 1'b0);
        chk($sformatf("v%0d overrun after ack", k), overrun, vt[k].exp_ovr);
        chk($sformatf("v%0d rxbyte after ack", k), rxbyte, vt[k].exp_byte);
      end
    end
    auto_ack = 1'b0;

    // Glitch: 20 clk low pulse
    caps0 = cap_q.size();
    fe0   = fe_cnt;
    rx = 1'b0;
    hold(10);
    settle();
    chk("glitch busy during", busy, 1'b1);
    hold(10);
    rx = 1'b1;
    hold(150);
    settle();
    chk("glitch busy after", busy, 1'b0);
    chk("glitch new bytes", cap_q.size() - caps0, 0);
    chk("glitch rx_valid", rx_valid, 1'b0);
    chk("glitch frame_err", fe_cnt - fe0, 0);
    chk("glitch overrun kept", overrun, 1'b1);

    // Reset during data bit 4 of 0xFF
    caps0 = cap_q.size();
    fe0   = fe_cnt;
    rx = 1'b0;
    hold(BITC);
    rx = 1'b1;
    hold(4 * BITC + BITC / 2);
    rst = 1'b1;
    hold(1);
    rst = 1'b0;
    settle();
    chk("midrst rxbyte", rxbyte, 8'h00);
    chk("midrst rx_valid", rx_valid, 1'b0);
    chk("midrst overrun", overrun, 1'b0);
    chk("midrst frame_err", frame_err, 1'b0);
    chk("midrst busy", busy, 1'b0);
    hold(800);
    settle();
    chk("midrst no byte", cap_q.size() - caps0, 0);
    chk("midrst no frame_err", fe_cnt - fe0, 0);
    chk("midrst rx_valid later", rx_valid, 1'b0);

    send(8'h3C, 1'b1);
    hold(20);
    settle();
    chk("post-rst new bytes", cap_q.size() - caps0, 1);
    chk("post-rst rxbyte", rxbyte, 8'h3C);
    chk("post-rst rx_valid", rx_valid, 1'b1);
    chk("post-rst overrun", overrun, 1'b0);
    chk("post-rst frame_err", fe_cnt - fe0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
